// File: rtl/div_arbiter.sv
// div_arbiter: round-robin scheduler sharing one fixed-latency sequential
// divider among NREQ requesters. Divisor-zero requests are answered locally
// with 8'hFF without starting the divider.
module div_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned DIV_LATENCY = 11
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_dividend,
  input  logic [16*NREQ-1:0]   req_divisor,
  output logic [NREQ-1:0]      ack,
  output logic                 res_valid,
  output logic [7:0]           res_q,
  output logic [2:0]           res_id,
  output logic                 busy,
  output logic                 div_start,
  output logic [15:0]          div_dividend,
  output logic [15:0]          div_divisor,
  input  logic [7:0]           div_q
);

  localparam int unsigned IDW  = 3;
  localparam int unsigned OPW  = 16;
  localparam int unsigned CNTW = $clog2(DIV_LATENCY);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESULT} state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic [OPW-1:0]     op_dvd_q, op_dvd_d;
  logic [OPW-1:0]     op_dvs_q, op_dvs_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]    ack_q, ack_d;
  logic               res_valid_q, res_valid_d;
  logic [7:0]         res_q_q, res_q_d;
  logic [IDW-1:0]     res_id_q, res_id_d;
  logic               busy_q, busy_d;
  logic               div_start_q, div_start_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [OPW-1:0]     grant_dvd;
  logic [OPW-1:0]     grant_dvs;
  int unsigned        scan_idx;

  // Round-robin search: first pending request above the last-served pointer
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_dvd   = '0;
    grant_dvs   = '0;
    scan_idx    = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      scan_idx = (32'(ptr_q) + 32'd1 + i) % NREQ;
      if (!grant_found && (|(req & (NREQ'(1) << scan_idx)))) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
        grant_dvd   = OPW'(req_dividend >> (OPW * scan_idx));
        grant_dvs   = OPW'(req_divisor >> (OPW * scan_idx));
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cur_id_d    = cur_id_q;
    op_dvd_d    = op_dvd_q;
    op_dvs_d    = op_dvs_q;
    cnt_d       = cnt_q;
    ack_d       = '0;
    res_valid_d = 1'b0;
    res_q_d     = res_q_q;
    res_id_d    = res_id_q;
    div_start_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          ptr_d       = grant_idx;
          cur_id_d    = grant_idx;
          op_dvd_d    = grant_dvd;
          op_dvs_d    = grant_dvs;
          ack_d       = NREQ'(1) << grant_idx;
          // start pulse lines up with ISSUE; skipped when answering locally
          div_start_d = (grant_dvs != '0);
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (op_dvs_q != '0) begin
          cnt_d   = CNTW'(DIV_LATENCY - 1);
          state_d = WAIT;
        end else begin
          res_q_d     = 8'hFF;
          res_id_d    = cur_id_q;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          res_q_d     = div_q;
          res_id_d    = cur_id_q;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      cur_id_q    <= '0;
      op_dvd_q    <= '0;
      op_dvs_q    <= '0;
      cnt_q       <= '0;
      ack_q       <= '0;
      res_valid_q <= 1'b0;
      res_q_q     <= '0;
      res_id_q    <= '0;
      busy_q      <= 1'b0;
      div_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cur_id_q    <= cur_id_d;
      op_dvd_q    <= op_dvd_d;
      op_dvs_q    <= op_dvs_d;
      cnt_q       <= cnt_d;
      ack_q       <= ack_d;
      res_valid_q <= res_valid_d;
      res_q_q     <= res_q_d;
      res_id_q    <= res_id_d;
      busy_q      <= busy_d;
      div_start_q <= div_start_d;
    end
  end

  assign ack          = ack_q;
  assign res_valid    = res_valid_q;
  assign res_q        = res_q_q;
  assign res_id       = res_id_q;
  assign busy         = busy_q;
  assign div_start    = div_start_q;
  assign div_dividend = op_dvd_q;
  assign div_divisor  = op_dvs_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: stub divider, result scoreboard, per-scenario tasks.
module tb_div_arbiter;

  localparam int NREQ = 4;

  logic                 clk = 1'b0;
  logic                 nrst;
  logic [NREQ-1:0]      req;
  logic [16*NREQ-1:0]   req_dividend;
  logic [16*NREQ-1:0]   req_divisor;
  logic [NREQ-1:0]      ack;
  logic                 res_valid;
  logic [7:0]           res_q;
  logic [2:0]           res_id;
  logic                 busy;
  logic                 div_start;
  logic [15:0]          div_dividend;
  logic [15:0]          div_divisor;
  logic [7:0]           div_q;

  typedef struct {
    logic [2:0] id;
    logic [7:0] q;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [4:0] stub_cnt;

  div_arbiter #(.NREQ(NREQ), .DIV_LATENCY(11)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .req          (req),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .ack          (ack),
    .res_valid    (res_valid),
    .res_q        (res_q),
    .res_id       (res_id),
    .busy         (busy),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_q        (div_q)
  );

  always #5 clk = ~clk;

  // Stub divider: A5 only in the cycle after edge E0+10
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stub_cnt <= '0;
      div_q    <= 8'h00;
    end else begin
      if (div_start)            stub_cnt <= 5'd1;
      else if (stub_cnt != 0 && stub_cnt < 5'd20) stub_cnt <= stub_cnt + 5'd1;
      else                      stub_cnt <= '0;
      div_q <= (stub_cnt == 5'd10) ? 8'hA5 : 8'h00;
    end
  end

  // Scoreboard: every res_valid pops and checks one expected result
  always @(negedge clk) begin
    if (nrst && res_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL res_unexpected: got id=%0d q=%h, required no result", res_id, res_q);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (res_id !== e.id || res_q !== e.q) begin
          n_fail++;
          $display("FAIL res_data: got id=%0d q=%h, required id=%0d q=%h", res_id, res_q, e.id, e.q);
        end
      end
    end
  end

  task automatic push_exp(input logic [2:0] id, input logic [7:0] q);
    exp_t e;
    e.id = id;
    e.q  = q;
    exp_q.push_back(e);
  endtask

  task automatic set_ops(input int i, input logic [15:0] dvd, input logic [15:0] dvs);
    req_dividend[16*i +: 16] = dvd;
    req_divisor[16*i +: 16]  = dvs;
  endtask

  // Waits (bounded) for an ack pulse; reports index (-1 on timeout) and negedges elapsed
  task automatic wait_ack(output int idx, output int cyc);
    idx = -1;
    cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (ack != '0) begin
        for (int b = 0; b < NREQ; b++) if (ack[b]) idx = b;
        break;
      end
    end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req = '0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'd100 + 16'(i), 16'd3);
    nrst = 1'b0;
    #3;
    n_checks++;
    if ({ack, res_valid, res_q, res_id, busy, div_start, div_dividend, div_divisor} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b rv=%b q=%h id=%0d busy=%b ds=%b dvd=%0d dvs=%0d, required all 0",
               ack, res_valid, res_q, res_id, busy, div_start, div_dividend, div_divisor);
    end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || ack !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b ack=%b, required busy=0 ack=0000", busy, ack);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    set_ops(0, 16'd1000, 16'd10);
    req = 4'b0001;
    push_exp(3'd0, 8'hA5);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0001 || div_start !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_ack: got ack=%b ds=%b busy=%b, required ack=0001 ds=1 busy=1", ack, div_start, busy);
    end
    n_checks++;
    if (div_dividend !== 16'd1000 || div_divisor !== 16'd10) begin
      n_fail++;
      $display("FAIL single_ops: got dvd=%0d dvs=%0d, required dvd=1000 dvs=10", div_dividend, div_divisor);
    end
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      n_checks++;
      if (res_valid !== 1'b0 || ack !== '0 || div_start !== 1'b0) begin
        n_fail++;
        $display("FAIL single_wait: cycle G+%0d got rv=%b ack=%b ds=%b, required 0", c, res_valid, ack, div_start);
      end
    end
    n_checks++;
    if (div_dividend !== 16'd1000 || div_divisor !== 16'd10) begin
      n_fail++;
      $display("FAIL single_ops_stable: got dvd=%0d dvs=%0d, required 1000/10", div_dividend, div_divisor);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL single_latency: got rv=%b at G+13, required 1", res_valid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_q !== 8'hA5 || res_id !== 3'd0) begin
      n_fail++;
      $display("FAIL single_hold: got busy=%b rv=%b q=%h id=%0d, required busy=0 rv=0 q=a5 id=0",
               busy, res_valid, res_q, res_id);
    end
  endtask

  task automatic test_div_zero();
    @(posedge clk); #1;
    set_ops(1, 16'd77, 16'd0);
    req = 4'b0010;
    push_exp(3'd1, 8'hFF);
    @(posedge clk); #1;
    req = '0;
    @(negedge clk);
    n_checks++;
    if (ack !== 4'b0010 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_ack: got ack=%b ds=%b, required ack=0010 ds=0", ack, div_start);
    end
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b1 || res_q !== 8'hFF || res_id !== 3'd1 || div_start !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_result: got rv=%b q=%h id=%0d ds=%b, required rv=1 q=ff id=1 ds=0",
               res_valid, res_q, res_id, div_start);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_idle: got busy=%b at G+3, required 0", busy);
    end
    set_ops(1, 16'd200, 16'd7);
  endtask

  task automatic test_round_robin();
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    int idx, cyc;
    nrst = 1'b0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'd500 + 16'(i), 16'd5);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(3'(exp_idx[k]), 8'hA5);
    do_reset();
    for (int k = 0; k < 5; k++) begin
      wait_ack(idx, cyc);
      n_checks++;
      if (idx !== exp_idx[k] || cyc !== (k == 0 ? 2 : 14)) begin
        n_fail++;
        $display("FAIL rr_grant%0d: got idx=%0d after %0d cycles, required idx=%0d after %0d",
                 k, idx, cyc, exp_idx[k], (k == 0 ? 2 : 14));
      end
    end
    @(posedge clk); #1;
    req = '0;
    drain(14);
  endtask

  task automatic test_fairness();
    int idx, cyc;
    @(posedge clk); #1;
    req = 4'b0100;
    push_exp(3'd2, 8'hA5);
    wait_ack(idx, cyc);
    n_checks++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL fair_serve2: got idx=%0d, required 2", idx);
    end
    @(posedge clk); #1;
    req = '0;
    drain(13);
    req = 4'b0101;
    push_exp(3'd0, 8'hA5);
    push_exp(3'd2, 8'hA5);
    wait_ack(idx, cyc);
    n_checks++;
    if (idx !== 0 || cyc !== 2) begin
      n_fail++;
      $display("FAIL fair_first: got idx=%0d after %0d, required idx=0 after 2", idx, cyc);
    end
    @(posedge clk); #1;
    req = 4'b0100;
    wait_ack(idx, cyc);
    n_checks++;
    if (idx !== 2 || cyc !== 14) begin
      n_fail++;
      $display("FAIL fair_second: got idx=%0d after %0d, required idx=2 after 14", idx, cyc);
    end
    @(posedge clk); #1;
    req = '0;
    drain(14);
  endtask

  task automatic test_reset_mid_wait();
    int idx, cyc;
    @(posedge clk); #1;
    set_ops(0, 16'd1234, 16'd9);
    req = 4'b0001;
    @(posedge clk); #1;
    req = '0;
    repeat (5) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    n_checks++;
    if ({ack, res_valid, res_q, res_id, busy, div_start, div_dividend, div_divisor} !== '0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ack=%b rv=%b q=%h id=%0d busy=%b ds=%b dvd=%0d dvs=%0d, required all 0",
               ack, res_valid, res_q, res_id, busy, div_start, div_dividend, div_divisor);
    end
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk); #1;
    set_ops(3, 16'd4000, 16'd40);
    req = 4'b1000;
    push_exp(3'd3, 8'hA5);
    wait_ack(idx, cyc);
    n_checks++;
    if (idx !== 3 || cyc !== 2) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got idx=%0d after %0d, required idx=3 after 2", idx, cyc);
    end
    @(posedge clk); #1;
    req = '0;
    drain(14);
  endtask

  task automatic test_busy_request();
    int idx, cyc;
    @(posedge clk); #1;
    set_ops(0, 16'd900, 16'd30);
    req = 4'b0001;
    push_exp(3'd0, 8'hA5);
    @(posedge clk); #1;
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    set_ops(3, 16'd60, 16'd6);
    req = 4'b1000;
    push_exp(3'd3, 8'hA5);
    wait_ack(idx, cyc);
    n_checks++;
    if (idx !== 3 || cyc !== 12) begin
      n_fail++;
      $display("FAIL busy_pending: got idx=%0d after %0d (from G+4), required idx=3 after 12", idx, cyc);
    end
    @(posedge clk); #1;
    req = '0;
    drain(14);
  endtask

  initial begin
    nrst         = 1'b0;
    req          = '0;
    req_dividend = '0;
    req_divisor  = '0;
    test_reset();
    test_single();
    test_div_zero();
    test_round_robin();
    test_fairness();
    test_reset_mid_wait();
    test_busy_request();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin scheduler that shares the single sequential divider among NREQ requesters, such as per-voice rate and duty computations. It latches a requester's operands and issues a one-cycle start to the divider. Because the divider has no done output, it waits a fixed latency, then captures the 8-bit quotient and returns it tagged with the requester id. Divisor-zero requests are answered locally without occupying the divider.

## Interface
- NREQ, 4, number of requesters (2..8)
- DIV_LATENCY, 11, edges from the edge sampling div_start to the edge capturing div_q (≥ 11 for the current divider)
- clk  in  1  system clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- req  in  NREQ  per-requester request level
- req_dividend  in  16*NREQ  requester i dividend at [16i+15:16i]
- req_divisor  in  16*NREQ  requester i divisor at [16i+15:16i]
- ack  out  NREQ  one-hot one-cycle pulse: operands of requester i latched
- res_valid  out  1  one-cycle pulse: res_q / res_id valid
- res_q  out  8  quotient
- res_id  out  3  requester index of the result
- busy  out  1  high in every state except IDLE
- div_start  out  1  one-cycle start pulse to divider flag input
- div_dividend  out  16  to divider count input
- div_divisor  out  16  to divider divider input
- div_q  in  8  divider q_out

## Operation
- States: IDLE, ISSUE, WAIT, RESULT.
- IDLE:
  - If any req bit is set, grant the first set bit searching upward from ptr+1 mod NREQ.
  - Latch that requester's dividend and divisor into op_dvd/op_dvs and its index into cur_id.
  - Set ptr = granted index, then go to ISSUE.
- ISSUE (1 cycle):
  - ack[cur_id]=1.
  - If op_dvs != 0: div_start=1, load wait counter with DIV_LATENCY-1, go to WAIT.
  - If op_dvs == 0: div_start=0, set res_q=8'hFF, go to RESULT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, register div_q into res_q and go to RESULT.
- RESULT (1 cycle): res_valid=1, res_id=cur_id, go to IDLE.
- div_dividend = op_dvd and div_divisor = op_dvs, registered and stable from ISSUE until the next grant.
- Requester handshake:
  - Operands need only be valid in the IDLE cycle where the grant occurs.
  - A requester should drop req in the cycle after its ack.
  - A req still high after ack is re-served when its turn comes again.
  - A req dropped before grant is never served.
- Fairness: after serving i, every other pending requester is served before i again.
- res_q holds its last value between results. res_id likewise holds.
- Reset values:
  - state=IDLE, ptr=NREQ-1 (requester 0 has first priority).
  - ack=0, res_valid=0, res_q=0, res_id=0, busy=0.
  - div_start=0, div_dividend=0, div_divisor=0, counter=0.

## Timing
- Request sampled in IDLE cycle G.
- ack and div_start are high in cycle G+1. The divider samples the start at edge E0, which ends G+1.
- WAIT occupies cycles G+2..G+1+DIV_LATENCY; div_q is captured at edge E0+DIV_LATENCY.
- res_valid is high in cycle G+2+DIV_LATENCY; the default gives G+13.
- IDLE resumes at G+3+DIV_LATENCY, so back-to-back throughput is DIV_LATENCY+3 cycles.
- Divisor-zero path: ack at G+1, res_valid with 8'hFF at G+2, next IDLE at G+3.
- div_start is never asserted while state != ISSUE. Hence no new start reaches the divider before the previous quotient is captured.
- Requests arriving while busy are held pending, not lost, provided req stays high.
- Asynchronous reset mid-operation:
  - All outputs return to reset values immediately.
  - The in-flight result is discarded with no res_valid.
  - The divider shares nrst and also resets.

## Test plan
- Use a stub divider that drives div_q=8'hA5 only in the cycle after edge E0+10 and 8'h00 otherwise.
- Single request: req=4'b0001, dvd=16'd1000, dvs=16'd10 at G.
  - ack=0001 and div_start at G+1; div_dividend=1000 and div_divisor=10 from G+1.
  - res_valid at G+13 with res_q=8'hA5, res_id=0.
- Round-robin: req=4'b1111 held continuously from reset.
  - Grants go 0,1,2,3,0 at 14-cycle spacing.
  - Each res_id matches the preceding ack index.
- Pointer fairness: serve requester 2, then assert req=4'b0101.
  - Next grant is 0, then 2.
- Divisor zero: requester 1 with dvs=0.
  - ack at G+1, div_start stays 0, res_valid at G+2 with res_q=8'hFF, res_id=1.
- Reset mid-WAIT: drop nrst at G+6.
  - All outputs are 0 immediately and no res_valid follows.
  - After release, req=4'b1000 is granted normally with ack=1000 one cycle after its IDLE sample.
- Request while busy: assert req[3] at G+4 during WAIT for requester 0.
  - ack[3] occurs at G+15.
